// File: rtl/fifo18k_sync_ctrl.sv
// fifo18k_sync_ctrl: pointer, count and flag controller for an 18Kb block-RAM
// synchronous FIFO. Generates the RAM strobes/addresses and registered status.
module fifo18k_sync_ctrl #(
  parameter int          DATA_WIDTH        = 18,
  parameter logic [10:0] PROG_EMPTY_THRESH = 11'h004,
  parameter logic [10:0] PROG_FULL_THRESH  = 11'h3fa
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        WR_EN,
  input  logic        RD_EN,
  output logic        RAM_WE,
  output logic [10:0] RAM_WADDR,
  output logic        RAM_RE,
  output logic [10:0] RAM_RADDR,
  output logic        RD_VALID,
  output logic [11:0] WORD_COUNT,
  output logic        EMPTY,
  output logic        FULL,
  output logic        ALMOST_EMPTY,
  output logic        ALMOST_FULL,
  output logic        PROG_EMPTY,
  output logic        PROG_FULL,
  output logic        OVERFLOW,
  output logic        UNDERFLOW
);

  localparam int          DEPTH     = 18432 / DATA_WIDTH;
  localparam logic [11:0] DEPTH_CNT = 12'(DEPTH);
  localparam logic [11:0] ALMOST_FULL_CNT = 12'(DEPTH - 1);
  localparam logic [10:0] LAST_ADDR = 11'(DEPTH - 1);

  if (!(DATA_WIDTH == 9 || DATA_WIDTH == 18)) begin : g_bad_width
    $error("fifo18k_sync_ctrl: DATA_WIDTH must be 9 or 18");
  end
  if (int'(PROG_EMPTY_THRESH) > DEPTH) begin : g_bad_pe_thresh
    $error("fifo18k_sync_ctrl: PROG_EMPTY_THRESH exceeds DEPTH");
  end
  if (int'(PROG_FULL_THRESH) > DEPTH) begin : g_bad_pf_thresh
    $error("fifo18k_sync_ctrl: PROG_FULL_THRESH exceeds DEPTH");
  end

  logic [10:0] wrPtr_q, wrPtr_d;
  logic [10:0] rdPtr_q, rdPtr_d;
  logic [11:0] count_q, count_d;
  logic        rdValid_q;
  logic        empty_q, full_q, almostEmpty_q, almostFull_q;
  logic        progEmpty_q, progFull_q, overflow_q, underflow_q;
  logic        wrAccept, rdAccept;

  // Accept decisions use the registered flags; reset masks both strobes.
  always_comb begin
    wrAccept = RESET_N & WR_EN & ~full_q;
    rdAccept = RESET_N & RD_EN & ~empty_q;

    wrPtr_d = wrPtr_q;
    if (wrAccept) wrPtr_d = (wrPtr_q == LAST_ADDR) ? 11'd0 : wrPtr_q + 11'd1;

    rdPtr_d = rdPtr_q;
    if (rdAccept) rdPtr_d = (rdPtr_q == LAST_ADDR) ? 11'd0 : rdPtr_q + 11'd1;

    count_d = count_q;
    case ({wrAccept, rdAccept})
      2'b10:   count_d = count_q + 12'd1;
      2'b01:   count_d = count_q - 12'd1;
      default: count_d = count_q;
    endcase
  end

  // State update; flags are derived from the next count so they line up with it.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      rdValid_q     <= 1'b0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      almostEmpty_q <= 1'b0;
      almostFull_q  <= 1'b0;
      progEmpty_q   <= 1'b1;
      progFull_q    <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      rdValid_q     <= rdAccept;
      empty_q       <= (count_d == 12'd0);
      full_q        <= (count_d == DEPTH_CNT);
      almostEmpty_q <= (count_d == 12'd1);
      almostFull_q  <= (count_d == ALMOST_FULL_CNT);
      progEmpty_q   <= (count_d <= {1'b0, PROG_EMPTY_THRESH});
      progFull_q    <= (count_d >= {1'b0, PROG_FULL_THRESH});
      overflow_q    <= WR_EN & full_q;
      underflow_q   <= RD_EN & empty_q;
    end
  end

  assign RAM_WE       = wrAccept;
  assign RAM_WADDR    = wrPtr_q;
  assign RAM_RE       = rdAccept;
  assign RAM_RADDR    = rdPtr_q;
  assign RD_VALID     = rdValid_q;
  assign WORD_COUNT   = count_q;
  assign EMPTY        = empty_q;
  assign FULL         = full_q;
  assign ALMOST_EMPTY = almostEmpty_q;
  assign ALMOST_FULL  = almostFull_q;
  assign PROG_EMPTY   = progEmpty_q;
  assign PROG_FULL    = progFull_q;
  assign OVERFLOW     = overflow_q;
  assign UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_fifo18k_sync_ctrl.sv
// tb_fifo18k_sync_ctrl: directed and randomized bench for fifo18k_sync_ctrl
// (DATA_WIDTH=18) against a queue-based reference model of the FIFO.
module tb_fifo18k_sync_ctrl;

  localparam int DEPTH   = 1024;
  localparam int PE_TH   = 4;
  localparam int PF_TH   = 1018;
  localparam logic [8:0] RESET_FLAGS = 9'b100010000;

  logic        clk;
  logic        resetN, wrEn, rdEn;
  logic        RAM_WE, RAM_RE, RD_VALID;
  logic [10:0] RAM_WADDR, RAM_RADDR;
  logic [11:0] WORD_COUNT;
  logic        EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, PROG_EMPTY, PROG_FULL;
  logic        OVERFLOW, UNDERFLOW;
  logic [8:0]  dutFlags;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: queue of addresses written and not yet read.
  int addrQ[$];
  int wrCount = 0, rdCount = 0;
  bit mOverflow = 0, mUnderflow = 0, mRdValid = 0;

  logic        expWe, expRe, obsWe, obsRe;
  logic [10:0] expWaddr, expRaddr, obsWaddr, obsRaddr;

  fifo18k_sync_ctrl #(
    .DATA_WIDTH(18),
    .PROG_EMPTY_THRESH(11'h004),
    .PROG_FULL_THRESH(11'h3fa)
  ) dut (
    .CLK(clk), .RESET_N(resetN), .WR_EN(wrEn), .RD_EN(rdEn),
    .RAM_WE(RAM_WE), .RAM_WADDR(RAM_WADDR), .RAM_RE(RAM_RE), .RAM_RADDR(RAM_RADDR),
    .RD_VALID(RD_VALID), .WORD_COUNT(WORD_COUNT),
    .EMPTY(EMPTY), .FULL(FULL), .ALMOST_EMPTY(ALMOST_EMPTY), .ALMOST_FULL(ALMOST_FULL),
    .PROG_EMPTY(PROG_EMPTY), .PROG_FULL(PROG_FULL),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  assign dutFlags = {EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, PROG_EMPTY, PROG_FULL,
                     OVERFLOW, UNDERFLOW, RD_VALID};

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected registered status from the model's current occupancy.
  function automatic logic [8:0] expFlags();
    int n = addrQ.size();
    return {n == 0, n == DEPTH, n == 1, n == DEPTH - 1, n <= PE_TH, n >= PF_TH,
            mOverflow, mUnderflow, mRdValid};
  endfunction

  // One clock of stimulus from a negedge: captures strobes/addresses mid-cycle,
  // advances the model at the rising edge, returns at the following negedge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic rstn);
    int  sz;
    bit  isFull, isEmpty, wa, ra;
    wrEn = wr; rdEn = rd; resetN = rstn;
    sz = addrQ.size();
    isFull = (sz == DEPTH);
    isEmpty = (sz == 0);
    wa = rstn && wr && !isFull;
    ra = rstn && rd && !isEmpty;
    expWe = wa;
    expRe = ra;
    expWaddr = 11'(wrCount % DEPTH);
    expRaddr = ra ? 11'(addrQ[0]) : 11'(rdCount % DEPTH);
    #1;
    obsWe = RAM_WE; obsRe = RAM_RE; obsWaddr = RAM_WADDR; obsRaddr = RAM_RADDR;
    @(posedge clk);
    if (!rstn) begin
      addrQ.delete();
      wrCount = 0; rdCount = 0;
      mOverflow = 0; mUnderflow = 0; mRdValid = 0;
    end else begin
      mOverflow = wr && isFull;
      mUnderflow = rd && isEmpty;
      mRdValid = ra;
      if (ra) begin void'(addrQ.pop_front()); rdCount++; end
      if (wa) begin addrQ.push_back(wrCount % DEPTH); wrCount++; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    nChecks++;
    if (obsWe !== 1'b0 || obsRe !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_strobes: we=%b re=%b, required 0 0", obsWe, obsRe);
    end
    nChecks++;
    if (dutFlags !== RESET_FLAGS || WORD_COUNT !== 12'd0) begin
      nFails++; $display("[TB] FAIL reset_state: flags=%b count=%0d, required %b 0", dutFlags, WORD_COUNT, RESET_FLAGS);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    nChecks++;
    if (dutFlags !== RESET_FLAGS || WORD_COUNT !== 12'd0) begin
      nFails++; $display("[TB] FAIL idle_state: flags=%b count=%0d, required %b 0", dutFlags, WORD_COUNT, RESET_FLAGS);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      nChecks++;
      if (obsWe !== 1'b1 || obsWaddr !== 11'(i)) begin
        nFails++; $display("[TB] FAIL fill_waddr[%0d]: we=%b addr=%0d, required 1 %0d", i, obsWe, obsWaddr, i);
      end
      nChecks++;
      if (ALMOST_FULL !== (i + 1 == DEPTH - 1) || FULL !== (i + 1 == DEPTH) ||
          PROG_FULL !== (i + 1 >= PF_TH) || WORD_COUNT !== 12'(i + 1)) begin
        nFails++; $display("[TB] FAIL fill_flags[%0d]: af=%b f=%b pf=%b cnt=%0d, required %b %b %b %0d", i,
          ALMOST_FULL, FULL, PROG_FULL, WORD_COUNT, i + 1 == DEPTH - 1, i + 1 == DEPTH, i + 1 >= PF_TH, i + 1);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    nChecks++;
    if (obsWe !== 1'b0 || OVERFLOW !== 1'b1 || WORD_COUNT !== 12'd1024) begin
      nFails++; $display("[TB] FAIL overflow: we=%b ovf=%b cnt=%0d, required 0 1 1024", obsWe, OVERFLOW, WORD_COUNT);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    nChecks++;
    if (OVERFLOW !== 1'b0 || FULL !== 1'b1) begin
      nFails++; $display("[TB] FAIL overflow_pulse: ovf=%b full=%b, required 0 1", OVERFLOW, FULL);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      nChecks++;
      if (obsRe !== 1'b1 || obsRaddr !== 11'(i)) begin
        nFails++; $display("[TB] FAIL drain_raddr[%0d]: re=%b addr=%0d, required 1 %0d", i, obsRe, obsRaddr, i);
      end
      nChecks++;
      if (RD_VALID !== 1'b1 || EMPTY !== (i == DEPTH - 1) || WORD_COUNT !== 12'(DEPTH - 1 - i)) begin
        nFails++; $display("[TB] FAIL drain_state[%0d]: rv=%b empty=%b cnt=%0d, required 1 %b %0d", i,
          RD_VALID, EMPTY, WORD_COUNT, i == DEPTH - 1, DEPTH - 1 - i);
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    nChecks++;
    if (obsRe !== 1'b0 || UNDERFLOW !== 1'b1 || RD_VALID !== 1'b0) begin
      nFails++; $display("[TB] FAIL underflow: re=%b unf=%b rv=%b, required 0 1 0", obsRe, UNDERFLOW, RD_VALID);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    nChecks++;
    if (UNDERFLOW !== 1'b0) begin
      nFails++; $display("[TB] FAIL underflow_pulse: unf=%b, required 0", UNDERFLOW);
    end
  endtask

  task automatic test_simultaneous();
    applyStimulus(1'b1, 1'b1, 1'b1);
    nChecks++;
    if (obsWe !== 1'b1 || obsRe !== 1'b0 || WORD_COUNT !== 12'd1 || UNDERFLOW !== 1'b1 || ALMOST_EMPTY !== 1'b1) begin
      nFails++; $display("[TB] FAIL both_at_empty: we=%b re=%b cnt=%0d unf=%b ae=%b, required 1 0 1 1 1",
        obsWe, obsRe, WORD_COUNT, UNDERFLOW, ALMOST_EMPTY);
    end
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    nChecks++;
    if (FULL !== 1'b1) begin
      nFails++; $display("[TB] FAIL refill: full=%b, required 1", FULL);
    end
    applyStimulus(1'b1, 1'b1, 1'b1);
    nChecks++;
    if (obsWe !== 1'b0 || obsRe !== 1'b1 || WORD_COUNT !== 12'd1023 || OVERFLOW !== 1'b1 || ALMOST_FULL !== 1'b1) begin
      nFails++; $display("[TB] FAIL both_at_full: we=%b re=%b cnt=%0d ovf=%b af=%b, required 0 1 1023 1 1",
        obsWe, obsRe, WORD_COUNT, OVERFLOW, ALMOST_FULL);
    end
  endtask

  task automatic test_wrap();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 1000; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 100; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      nChecks++;
      if (obsWe !== 1'b1 || obsWaddr !== 11'((1000 + k) % 1024)) begin
        nFails++; $display("[TB] FAIL wrap_waddr[%0d]: we=%b addr=%0d, required 1 %0d", k, obsWe, obsWaddr, (1000 + k) % 1024);
      end
    end
    nChecks++;
    if (WORD_COUNT !== 12'd100) begin
      nFails++; $display("[TB] FAIL wrap_count: cnt=%0d, required 100", WORD_COUNT);
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    nChecks++;
    if (WORD_COUNT !== 12'd500) begin
      nFails++; $display("[TB] FAIL pre_reset_count: cnt=%0d, required 500", WORD_COUNT);
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    nChecks++;
    if (obsWe !== 1'b0 || obsRe !== 1'b0 || dutFlags !== RESET_FLAGS || WORD_COUNT !== 12'd0) begin
      nFails++; $display("[TB] FAIL mid_reset: we=%b re=%b flags=%b cnt=%0d, required 0 0 %b 0",
        obsWe, obsRe, dutFlags, WORD_COUNT, RESET_FLAGS);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    nChecks++;
    if (obsWe !== 1'b1 || obsWaddr !== 11'd0 || WORD_COUNT !== 12'd1) begin
      nFails++; $display("[TB] FAIL post_reset_write: we=%b addr=%0d cnt=%0d, required 1 0 1", obsWe, obsWaddr, WORD_COUNT);
    end
  endtask

  task automatic test_random();
    logic wr, rd, rstn;
    int   wrBias;
    for (int i = 0; i < 3200; i++) begin
      wrBias = ((i / 1600) == 0) ? 90 : 10;
      wr = ($urandom_range(0, 99) < wrBias);
      rd = ($urandom_range(0, 99) < (100 - wrBias));
      rstn = ($urandom_range(0, 499) != 0);
      applyStimulus(wr, rd, rstn);
      nChecks++;
      if (obsWe !== expWe || obsRe !== expRe || (expWe && obsWaddr !== expWaddr) || (expRe && obsRaddr !== expRaddr)) begin
        nFails++; $display("[TB] FAIL rand_strobes[%0d]: we=%b wa=%0d re=%b ra=%0d, required %b %0d %b %0d",
          i, obsWe, obsWaddr, obsRe, obsRaddr, expWe, expWaddr, expRe, expRaddr);
      end
      nChecks++;
      if (dutFlags !== expFlags() || WORD_COUNT !== 12'(addrQ.size())) begin
        nFails++; $display("[TB] FAIL rand_state[%0d]: flags=%b cnt=%0d, required %b %0d",
          i, dutFlags, WORD_COUNT, expFlags(), addrQ.size());
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    wrEn = 1'b0; rdEn = 1'b0; resetN = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
